// File: rtl/svm_pkg.sv
// Shared definitions for the SVM window sequencer: the controller FSM
// state encoding and the default window geometry and datapath widths.
package svm_pkg;

  // Default detection window geometry in HOG blocks
  localparam int WIN_BW   = 7;
  localparam int WIN_BH   = 15;
  localparam int WIN_BLKS = WIN_BW * WIN_BH;

  // Default datapath widths
  localparam int BID_W = 13;
  localparam int CIX_W = 7;
  localparam int ACC_W = 48;

  // Window controller states, walked in order once per window
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLR   = 3'd1,
    ACCUM = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/svm_win_ctrl_if.sv
// Block stream and MAC datapath link of the SVM window sequencer.
// The master side is the controller: it accepts blocks, steers the MAC
// array and receives the accumulated sum. The slave side is the
// normalizer/MAC pair that feeds blocks and returns the sum.
interface svm_win_ctrl_if #(
  parameter int CIX_W = 7,
  parameter int ACC_W = 48
) ();

  logic                    blk_valid;
  logic                    blk_ready;
  logic                    mac_clr;
  logic                    mac_en;
  logic                    mac_last;
  logic [CIX_W-1:0]        coe_idx;
  logic signed [ACC_W-1:0] sum;
  logic                    sum_valid;

  modport master (
    input  blk_valid,
    input  sum,
    input  sum_valid,
    output blk_ready,
    output mac_clr,
    output mac_en,
    output mac_last,
    output coe_idx
  );

  modport slave (
    output blk_valid,
    output sum,
    output sum_valid,
    input  blk_ready,
    input  mac_clr,
    input  mac_en,
    input  mac_last,
    input  coe_idx
  );

endinterface

// File: rtl/svm_win_ctrl.sv
// SVM detection window sequencer.
// Owns one window at a time: clears the MAC accumulator, admits the
// window's WIN_BW*WIN_BH blocks with a coefficient index per block, waits
// for the accumulated sum, adds the bias and emits one verdict.
// The verdict flops make det_valid appear two cycles after sum_valid.
// Score arithmetic is ACC_W-bit two's complement; sum + BIAS wraps on
// overflow rather than saturating.
// Optional build macro SVM_SCORE_OUT_EN: adds output det_score carrying
// the score of the latest verdict (held until the next verdict).
module svm_win_ctrl
  import svm_pkg::*;
#(
  parameter int                      WIN_BW = 7,
  parameter int                      WIN_BH = 15,
  parameter int                      BID_W  = 13,
  parameter int                      CIX_W  = 7,
  parameter int                      ACC_W  = 48,
  parameter logic signed [ACC_W-1:0] BIAS   = '0,
  parameter logic signed [ACC_W-1:0] THRESH = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BID_W-1:0] win_id,
  input  logic             abort,
  svm_win_ctrl_if.master   dp,
  output logic             busy,
  output logic             det_valid,
  output logic             det_hit,
  output logic [BID_W-1:0] det_win_id
`ifdef SVM_SCORE_OUT_EN
  ,
  output logic [ACC_W-1:0] det_score
`endif
);

  localparam int BLKS = WIN_BW * WIN_BH;
  localparam logic [CIX_W-1:0] LAST_IDX = CIX_W'(BLKS - 1);

  state_e                  state_q, state_d;
  logic [CIX_W-1:0]        counter_q, counter_d;
  logic [BID_W-1:0]        win_id_q, win_id_d;
  logic signed [ACC_W-1:0] score_q, score_d;
  logic                    det_valid_q, det_valid_d;
  logic                    det_hit_q, det_hit_d;
  logic [BID_W-1:0]        det_win_id_q, det_win_id_d;

`ifdef SVM_SCORE_OUT_EN
  logic [ACC_W-1:0]        det_score_q, det_score_d;
`endif

  // Next-state, counter, score capture and MAC steering; abort overrides all
  always_comb begin
    state_d      = state_q;
    counter_d    = counter_q;
    win_id_d     = win_id_q;
    score_d      = score_q;
    det_valid_d  = 1'b0;
    det_hit_d    = 1'b0;
    det_win_id_d = det_win_id_q;
`ifdef SVM_SCORE_OUT_EN
    det_score_d  = det_score_q;
`endif
    dp.blk_ready = 1'b0;
    dp.mac_clr   = 1'b0;
    dp.mac_en    = 1'b0;
    dp.mac_last  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start && !abort) begin
          win_id_d = win_id;
          state_d  = CLR;
        end
      end

      CLR: begin
        dp.mac_clr = 1'b1;
        counter_d  = '0;
        state_d    = ACCUM;
      end

      ACCUM: begin
        dp.blk_ready = 1'b1;
        if (dp.blk_valid) begin
          dp.mac_en = 1'b1;
          if (counter_q == LAST_IDX) begin
            dp.mac_last = 1'b1;
            counter_d   = '0;
            state_d     = DRAIN;
          end else begin
            counter_d = counter_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (dp.sum_valid) begin
          score_d = dp.sum + BIAS;
          state_d = DONE;
        end
      end

      DONE: begin
        det_valid_d  = 1'b1;
        det_hit_d    = (score_q > THRESH);
        det_win_id_d = win_id_q;
`ifdef SVM_SCORE_OUT_EN
        det_score_d  = score_q;
`endif
        state_d      = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (abort && (state_q != IDLE)) begin
      state_d      = IDLE;
      counter_d    = '0;
      win_id_d     = win_id_q;
      score_d      = score_q;
      det_valid_d  = 1'b0;
      det_hit_d    = 1'b0;
      det_win_id_d = det_win_id_q;
`ifdef SVM_SCORE_OUT_EN
      det_score_d  = det_score_q;
`endif
      dp.blk_ready = 1'b0;
      dp.mac_clr   = 1'b0;
      dp.mac_en    = 1'b0;
      dp.mac_last  = 1'b0;
    end
  end

  // State, block counter, window id, score and verdict registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      counter_q    <= '0;
      win_id_q     <= '0;
      score_q      <= '0;
      det_valid_q  <= 1'b0;
      det_hit_q    <= 1'b0;
      det_win_id_q <= '0;
    end else begin
      state_q      <= state_d;
      counter_q    <= counter_d;
      win_id_q     <= win_id_d;
      score_q      <= score_d;
      det_valid_q  <= det_valid_d;
      det_hit_q    <= det_hit_d;
      det_win_id_q <= det_win_id_d;
    end
  end

`ifdef SVM_SCORE_OUT_EN
  // Published score of the latest verdict
  always_ff @(posedge clk) begin
    if (rst) begin
      det_score_q <= '0;
    end else begin
      det_score_q <= det_score_d;
    end
  end

  assign det_score = det_score_q;
`endif

  assign dp.coe_idx = counter_q;
  assign busy       = (state_q != IDLE);
  assign det_valid  = det_valid_q;
  assign det_hit    = det_hit_q;
  assign det_win_id = det_win_id_q;

endmodule

// File: tb/tb_svm_win_ctrl.sv
// Self-checking bench for svm_win_ctrl (BIAS=-50, THRESH=0).
module tb_svm_win_ctrl;

  localparam int NBLK = 105;
  localparam logic signed [47:0] TB_BIAS   = -48'sd50;
  localparam logic signed [47:0] TB_THRESH = 48'sd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [12:0] win_id;
  logic        abort;
  logic        busy;
  logic        det_valid;
  logic        det_hit;
  logic [12:0] det_win_id;
`ifdef SVM_SCORE_OUT_EN
  logic [47:0] det_score;
`endif

  svm_win_ctrl_if #(.CIX_W(7), .ACC_W(48)) dp_if ();

  svm_win_ctrl #(
    .WIN_BW(7), .WIN_BH(15), .BID_W(13), .CIX_W(7), .ACC_W(48),
    .BIAS(TB_BIAS), .THRESH(TB_THRESH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .win_id    (win_id),
    .abort     (abort),
    .dp        (dp_if),
    .busy      (busy),
    .det_valid (det_valid),
    .det_hit   (det_hit),
    .det_win_id(det_win_id)
`ifdef SVM_SCORE_OUT_EN
    ,
    .det_score (det_score)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int en_cnt, idx_err, last_cnt, last_bad, clr_cnt, overlap, det_cnt;

  typedef struct {
    logic [12:0]        id;
    logic signed [47:0] sum;
    int                 mode;
    logic               exp_hit;
  } vec_t;

  vec_t vecs[12];

  function automatic logic refHit(input logic signed [47:0] s);
    logic signed [47:0] sc;
    sc = s + TB_BIAS;
    return (sc > TB_THRESH);
  endfunction

  function automatic logic signed [47:0] rand48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic clearStats();
    en_cnt = 0; idx_err = 0; last_cnt = 0; last_bad = 0;
    clr_cnt = 0; overlap = 0; det_cnt = 0;
  endtask

  // Observes the MAC stream: the n-th accumulate of a window must carry
  // index n, and mac_last must mark exactly the final block
  always @(negedge clk) begin
    if (dp_if.mac_en) begin
      if (int'(dp_if.coe_idx) != en_cnt) idx_err++;
      if (dp_if.mac_last != (en_cnt == NBLK - 1)) last_bad++;
      en_cnt++;
    end
    if (dp_if.mac_last) last_cnt++;
    if (dp_if.mac_last && !dp_if.mac_en) last_bad++;
    if (dp_if.mac_clr) clr_cnt++;
    if (dp_if.mac_clr && dp_if.mac_en) overlap++;
    if (det_valid) det_cnt++;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Runs one window: mode 0 back-to-back, 1 toggling valid, 2 random bubbles.
  // abort_at >= 0 aborts while offering that block; junk injects a stray
  // start and sum_valid mid-window.
  task automatic applyStimulus(input logic [12:0] id, input logic signed [47:0] s,
                               input int mode, input int abort_at, input bit junk,
                               input logic exp_hit);
    int sent, cyc;
    bit aborted, tog, junk_done;
    clearStats();
    start = 1'b1; win_id = id;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    sent = 0; cyc = 0; aborted = 0; tog = 1; junk_done = 0;
    while (sent < NBLK && !aborted && cyc < 2000) begin
      case (mode)
        0:       dp_if.blk_valid = 1'b1;
        1:       begin dp_if.blk_valid = tog; tog = ~tog; end
        default: dp_if.blk_valid = ($urandom_range(0, 99) >= 30);
      endcase
      if (sent == abort_at) begin
        dp_if.blk_valid = 1'b1; abort = 1'b1; aborted = 1;
      end
      if (junk && !junk_done && sent == 30) begin
        start = 1'b1; win_id = ~id; dp_if.sum_valid = 1'b1; dp_if.sum = rand48();
        junk_done = 1;
      end
      @(negedge clk);
      if (dp_if.blk_valid && dp_if.blk_ready) sent++;
      tick();
      start = 1'b0; abort = 1'b0; dp_if.sum_valid = 1'b0; cyc++;
    end
    dp_if.blk_valid = 1'b0;
    if (cyc >= 2000) begin
      checkOutput("blk_timeout", 1, 0);
      return;
    end
    if (aborted) begin
      checkOutput("abort_idle", busy, 0);
      dp_if.sum_valid = 1'b1; dp_if.sum = 48'sd1000;
      tick();
      dp_if.sum_valid = 1'b0;
      repeat (4) tick();
      checkOutput("abort_no_det", det_cnt, 0);
      checkOutput("abort_en_cnt", en_cnt, abort_at);
      checkOutput("abort_no_last", last_cnt, 0);
      checkOutput("abort_busy", busy, 0);
      return;
    end
    repeat ($urandom_range(1, 4)) tick();
    checkOutput("drain_busy", busy, 1);
    checkOutput("drain_ready", dp_if.blk_ready, 0);
    dp_if.sum_valid = 1'b1; dp_if.sum = s;
    tick();
    dp_if.sum_valid = 1'b0; dp_if.sum = rand48();
    checkOutput("det_early", det_valid, 0);
    tick();
    checkOutput("det_valid", det_valid, 1);
    checkOutput("det_hit", det_hit, exp_hit);
    checkOutput("det_win_id", det_win_id, id);
    tick();
    checkOutput("det_pulse", det_valid, 0);
    checkOutput("mac_en_count", en_cnt, NBLK);
    checkOutput("coe_idx_seq", idx_err, 0);
    checkOutput("mac_last_count", last_cnt, 1);
    checkOutput("mac_last_pos", last_bad, 0);
    checkOutput("mac_clr_count", clr_cnt, 1);
    checkOutput("clr_en_overlap", overlap, 0);
    checkOutput("det_count", det_cnt, 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; win_id = '0; abort = 1'b0;
    dp_if.blk_valid = 1'b1; dp_if.sum = '0; dp_if.sum_valid = 1'b0;
    repeat (3) tick();
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_blk_ready", dp_if.blk_ready, 0);
    checkOutput("rst_mac_clr", dp_if.mac_clr, 0);
    checkOutput("rst_mac_en", dp_if.mac_en, 0);
    checkOutput("rst_mac_last", dp_if.mac_last, 0);
    checkOutput("rst_coe_idx", dp_if.coe_idx, 0);
    checkOutput("rst_det", {det_valid, det_hit, det_win_id}, 0);
    rst = 1'b0; dp_if.blk_valid = 1'b0;
    tick();

    vecs[0] = '{13'd37, 48'sd100, 0, 1'b1};
    vecs[1] = '{13'd5, 48'sd300, 1, 1'b1};
    vecs[2] = '{13'd6, 48'sd50, 2, 1'b0};
    vecs[3] = '{13'd7, 48'sd49, 0, 1'b0};
    vecs[4] = '{13'd8, 48'sd51, 1, 1'b1};
    vecs[5] = '{13'd9, 48'sh8000_0000_0000, 2, 1'b1};
    vecs[6] = '{13'd10, 48'sh7FFF_FFFF_FFFF, 0, 1'b1};
    vecs[7] = '{13'd11, -48'sd1000, 2, 1'b0};
    for (int i = 8; i < 12; i++) begin
      vecs[i].id   = 13'($urandom);
      vecs[i].sum  = rand48();
      vecs[i].mode = 2;
      vecs[i].exp_hit = refHit(vecs[i].sum);
    end

    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i].id, vecs[i].sum, vecs[i].mode, -1, 1'b0, vecs[i].exp_hit);
    end

    applyStimulus(13'd37, 48'sd100, 0, 60, 1'b0, 1'b1);
    applyStimulus(13'd38, 48'sd100, 2, -1, 1'b0, 1'b1);
    applyStimulus(13'd39, 48'sd100, 0, NBLK - 1, 1'b0, 1'b1);
    applyStimulus(13'd77, 48'sd20, 2, -1, 1'b1, 1'b0);
    applyStimulus(13'd78, 48'sd60, 1, -1, 1'b1, 1'b1);

    start = 1'b1; abort = 1'b1; win_id = 13'd99;
    tick();
    start = 1'b0; abort = 1'b0;
    checkOutput("start_abort_idle", busy, 0);
    tick();

    clearStats();
    start = 1'b1; win_id = 13'd55;
    tick();
    start = 1'b0;
    dp_if.blk_valid = 1'b1;
    repeat (NBLK + 1) tick();
    dp_if.blk_valid = 1'b0;
    tick();
    checkOutput("drain_before_rst", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_mac", {dp_if.blk_ready, dp_if.mac_clr, dp_if.mac_en, dp_if.mac_last}, 0);
    checkOutput("mid_rst_coe_idx", dp_if.coe_idx, 0);
    checkOutput("mid_rst_det", {det_valid, det_hit, det_win_id}, 0);
    dp_if.sum_valid = 1'b1; dp_if.sum = 48'sd500;
    tick();
    dp_if.sum_valid = 1'b0;
    repeat (4) tick();
    checkOutput("mid_rst_no_det", det_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
